// File: rtl/reg_paralelo_serie_tx_if.sv
// -----------------------------------------------------------------------------
// reg_paralelo_serie_tx_if
//   Bundle of the parallel handshake and serial output signals of
//   reg_paralelo_serie_tx.
//
//   master : the word producer (drives D/valid, observes the serial side)
//   slave  : the transmitter itself
//
//   D        parallel word to send, sampled on handshake
//   valid    D holds a word to send
//   ready    transmitter can accept a word this cycle
//   SO       serial data out
//   so_valid SO carries a frame bit
//   so_last  SO carries the final bit of the frame
//   busy     a frame is in progress
// -----------------------------------------------------------------------------
interface reg_paralelo_serie_tx_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] D;
  logic             valid;
  logic             ready;
  logic             SO;
  logic             so_valid;
  logic             so_last;
  logic             busy;

  modport master (
    output D,
    output valid,
    input  ready,
    input  SO,
    input  so_valid,
    input  so_last,
    input  busy
  );

  modport slave (
    input  D,
    input  valid,
    output ready,
    output SO,
    output so_valid,
    output so_last,
    output busy
  );
endinterface

// File: rtl/reg_paralelo_serie_tx.sv
// -----------------------------------------------------------------------------
// reg_paralelo_serie_tx
//   Parallel-in, serial-out transmitter. A WIDTH-bit word is taken over a
//   valid/ready handshake and shifted out one bit at a time, each bit held on
//   SO for DIV clock cycles. Back-to-back words are accepted in the final
//   cycle of the last bit, so a continuous valid gives a gapless stream.
//
//   Parameters
//     WIDTH     word width in bits (>= 2)
//     DIV       clock cycles each bit is held on SO (>= 1)
//     MSB_FIRST 1: D[WIDTH-1] sent first, 0: D[0] sent first
//
//   Ports
//     clk  system clock, rising edge
//     rst  asynchronous, active-high reset
//     bus  slave side of reg_paralelo_serie_tx_if
//          (D, valid in; ready, SO, so_valid, so_last, busy out)
// -----------------------------------------------------------------------------
module reg_paralelo_serie_tx #(
  parameter int WIDTH     = 4,
  parameter int DIV       = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  reg_paralelo_serie_tx_if.slave bus
);

  // Counter widths; a one-bit divider counter is kept even when DIV==1 so the
  // register is never zero-width.
  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [BIT_W-1:0] BIT_ZERO = {BIT_W{1'b0}};
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0] BIT_PEN  = BIT_W'(WIDTH - 2);
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  // Bit of the shift register that is presented on SO, and the bit that
  // moves into that position after one shift.
  localparam int OUT_IDX  = MSB_FIRST ? (WIDTH - 1) : 0;
  localparam int NEXT_IDX = MSB_FIRST ? (WIDTH - 2) : 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] sr_r;
  logic [BIT_W-1:0] bit_cnt_r;
  logic [DIV_W-1:0] div_cnt_r;
  logic             so_r;
  logic             so_valid_r;
  logic             so_last_r;
  logic             busy_r;

  logic             bit_last_s;
  logic             div_last_s;
  logic             ready_s;
  logic             accept_s;
  logic [WIDTH-1:0] sr_shift_s;

  // End-of-bit / end-of-frame decode and the shifted shift-register image.
  always_comb begin
    bit_last_s = (bit_cnt_r == BIT_LAST);
    div_last_s = (div_cnt_r == DIV_LAST);
    if (MSB_FIRST) begin
      sr_shift_s = {sr_r[WIDTH-2:0], 1'b0};
    end else begin
      sr_shift_s = {1'b0, sr_r[WIDTH-1:1]};
    end
  end

  // ready is open in IDLE and during the very last cycle of the last bit,
  // which is what allows a reload with no gap cycle. Held low during reset.
  always_comb begin
    ready_s = 1'b0;
    if (rst) begin
      ready_s = 1'b0;
    end else if (state_r == IDLE) begin
      ready_s = 1'b1;
    end else if (bit_last_s && div_last_s) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
  end

  // Handshake completes on the edge where both sides agree.
  always_comb begin
    accept_s = bus.valid & ready_s;
  end

  // Transmit FSM: state, datapath and registered outputs in one place. The
  // output registers are loaded with the values the new state/sr will imply,
  // so SO always mirrors sr_r[OUT_IDX] while a frame is in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      sr_r       <= {WIDTH{1'b0}};
      bit_cnt_r  <= BIT_ZERO;
      div_cnt_r  <= DIV_ZERO;
      so_r       <= 1'b0;
      so_valid_r <= 1'b0;
      so_last_r  <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r    <= SHIFT;
            sr_r       <= bus.D;
            bit_cnt_r  <= BIT_ZERO;
            div_cnt_r  <= DIV_ZERO;
            so_r       <= bus.D[OUT_IDX];
            so_valid_r <= 1'b1;
            so_last_r  <= 1'b0;
            busy_r     <= 1'b1;
          end else begin
            state_r    <= IDLE;
            so_r       <= 1'b0;
            so_valid_r <= 1'b0;
            so_last_r  <= 1'b0;
            busy_r     <= 1'b0;
          end
        end

        SHIFT: begin
          if (!div_last_s) begin
            // Still holding the current bit.
            div_cnt_r <= div_cnt_r + DIV_ONE;
          end else if (!bit_last_s) begin
            // Bit period over: advance to the next bit of the same frame.
            div_cnt_r <= DIV_ZERO;
            bit_cnt_r <= bit_cnt_r + BIT_ONE;
            sr_r      <= sr_shift_s;
            so_r      <= sr_r[NEXT_IDX];
            so_last_r <= (bit_cnt_r == BIT_PEN);
          end else if (accept_s) begin
            // Last bit done and a new word is waiting: reload, no gap.
            div_cnt_r  <= DIV_ZERO;
            bit_cnt_r  <= BIT_ZERO;
            sr_r       <= bus.D;
            so_r       <= bus.D[OUT_IDX];
            so_valid_r <= 1'b1;
            so_last_r  <= 1'b0;
            busy_r     <= 1'b1;
          end else begin
            // Last bit done with nothing queued: line returns to idle.
            state_r    <= IDLE;
            div_cnt_r  <= DIV_ZERO;
            bit_cnt_r  <= BIT_ZERO;
            so_r       <= 1'b0;
            so_valid_r <= 1'b0;
            so_last_r  <= 1'b0;
            busy_r     <= 1'b0;
          end
        end

        default: begin
          state_r    <= IDLE;
          sr_r       <= {WIDTH{1'b0}};
          bit_cnt_r  <= BIT_ZERO;
          div_cnt_r  <= DIV_ZERO;
          so_r       <= 1'b0;
          so_valid_r <= 1'b0;
          so_last_r  <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  // Drive the interface from the registered outputs.
  always_comb begin
    bus.ready    = ready_s;
    bus.SO       = so_r;
    bus.so_valid = so_valid_r;
    bus.so_last  = so_last_r;
    bus.busy     = busy_r;
  end

endmodule

// File: tb/tb_reg_paralelo_serie_tx.sv
// -----------------------------------------------------------------------------
// tb_reg_paralelo_serie_tx
//   Two transmitters driven with the same handshake stimulus:
//     u0 : WIDTH=4, DIV=1, MSB first
//     u1 : WIDTH=4, DIV=3, LSB first
//   A reference model expands each accepted word into its per-cycle stream of
//   (bit, last) entries in a queue; the head of the queue is what the line
//   must show in the current cycle, and an empty queue means idle.
// -----------------------------------------------------------------------------
module tb_reg_paralelo_serie_tx;

  localparam int W    = 4;
  localparam int DIV0 = 1;
  localparam bit MSB0 = 1'b1;
  localparam int DIV1 = 3;
  localparam bit MSB1 = 1'b0;

  typedef struct packed {
    logic so;
    logic last;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  ent_t q0[$];
  ent_t q1[$];

  // Per-cycle capture of the line (newest sample in bit 0).
  logic [15:0] cap0  = 16'h0000;
  logic [15:0] capv0 = 16'h0000;
  logic [15:0] capl0 = 16'h0000;
  logic [15:0] capr0 = 16'h0000;
  logic [15:0] cap1  = 16'h0000;
  logic [15:0] capl1 = 16'h0000;
  logic [15:0] capr1 = 16'h0000;

  reg_paralelo_serie_tx_if #(.WIDTH(W)) if0 ();
  reg_paralelo_serie_tx_if #(.WIDTH(W)) if1 ();

  reg_paralelo_serie_tx #(.WIDTH(W), .DIV(DIV0), .MSB_FIRST(MSB0)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  reg_paralelo_serie_tx #(.WIDTH(W), .DIV(DIV1), .MSB_FIRST(MSB1)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expand a word into its bit stream: bit k held div cycles, last on final bit.
  task automatic push_frame(input int inst, input logic [W-1:0] w);
    ent_t e;
    for (int k = 0; k < W; k++) begin
      e.so   = (inst == 0) ? (MSB0 ? w[W-1-k] : w[k]) : (MSB1 ? w[W-1-k] : w[k]);
      e.last = (k == W - 1);
      for (int r = 0; r < ((inst == 0) ? DIV0 : DIV1); r++) begin
        if (inst == 0) q0.push_back(e);
        else           q1.push_back(e);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_u0_so"},    {31'd0, if0.SO},       32'd0);
    check_eq({tag, "_u0_vld"},   {31'd0, if0.so_valid}, 32'd0);
    check_eq({tag, "_u0_last"},  {31'd0, if0.so_last},  32'd0);
    check_eq({tag, "_u0_busy"},  {31'd0, if0.busy},     32'd0);
    check_eq({tag, "_u0_ready"}, {31'd0, if0.ready},    32'd0);
    check_eq({tag, "_u1_so"},    {31'd0, if1.SO},       32'd0);
    check_eq({tag, "_u1_vld"},   {31'd0, if1.so_valid}, 32'd0);
    check_eq({tag, "_u1_busy"},  {31'd0, if1.busy},     32'd0);
    check_eq({tag, "_u1_ready"}, {31'd0, if1.ready},    32'd0);
  endtask

  // One clock cycle: at the falling edge compare the line with the model,
  // then drive the handshake and advance the model past the next rising edge.
  task automatic cycle(input logic v, input logic [W-1:0] d);
    ent_t e0;
    ent_t e1;
    logic act0;
    logic act1;
    logic rdy0;
    logic rdy1;
    @(negedge clk);
    act0 = (q0.size() > 0);
    act1 = (q1.size() > 0);
    e0   = act0 ? q0[0] : '0;
    e1   = act1 ? q1[0] : '0;
    rdy0 = !rst && (q0.size() <= 1);
    rdy1 = !rst && (q1.size() <= 1);
    check_eq("u0_so",    {31'd0, if0.SO},       {31'd0, e0.so});
    check_eq("u0_vld",   {31'd0, if0.so_valid}, {31'd0, act0});
    check_eq("u0_last",  {31'd0, if0.so_last},  {31'd0, e0.last});
    check_eq("u0_busy",  {31'd0, if0.busy},     {31'd0, act0});
    check_eq("u0_ready", {31'd0, if0.ready},    {31'd0, rdy0});
    check_eq("u1_so",    {31'd0, if1.SO},       {31'd0, e1.so});
    check_eq("u1_vld",   {31'd0, if1.so_valid}, {31'd0, act1});
    check_eq("u1_last",  {31'd0, if1.so_last},  {31'd0, e1.last});
    check_eq("u1_busy",  {31'd0, if1.busy},     {31'd0, act1});
    check_eq("u1_ready", {31'd0, if1.ready},    {31'd0, rdy1});
    cap0  = {cap0[14:0],  if0.SO};
    capv0 = {capv0[14:0], if0.so_valid};
    capl0 = {capl0[14:0], if0.so_last};
    capr0 = {capr0[14:0], if0.ready};
    cap1  = {cap1[14:0],  if1.SO};
    capl1 = {capl1[14:0], if1.so_last};
    capr1 = {capr1[14:0], if1.ready};
    if0.valid = v;
    if0.D     = d;
    if1.valid = v;
    if1.D     = d;
    if (act0) e0 = q0.pop_front();
    if (act1) e1 = q1.pop_front();
    if (v && rdy0) push_frame(0, d);
    if (v && rdy1) push_frame(1, d);
  endtask

  // Reset asserted between edges, held across one rising edge, then released.
  task automatic mid_reset();
    #2;
    rst       = 1'b1;
    if0.valid = 1'b0;
    if1.valid = 1'b0;
    #1;
    check_all_zero("rst_async");
    q0.delete();
    q1.delete();
    @(negedge clk);
    check_all_zero("rst_held");
    rst = 1'b0;
    #1;
    check_eq("rel_u0_ready", {31'd0, if0.ready}, 32'd1);
    check_eq("rel_u1_ready", {31'd0, if1.ready}, 32'd1);
  endtask

  initial begin
    if0.valid = 1'b0;
    if0.D     = '0;
    if1.valid = 1'b0;
    if1.D     = '0;

    // Power-on reset.
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("por");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("por_u0_ready", {31'd0, if0.ready}, 32'd1);
    check_eq("por_u1_ready", {31'd0, if1.ready}, 32'd1);

    // Idle hold with D toggling.
    for (int i = 0; i < 10; i++) cycle(1'b0, W'($urandom));

    // Single word 1011: u0 MSB first 1,0,1,1; u1 LSB first, 3 cycles per bit.
    cycle(1'b1, 4'b1011);
    for (int i = 0; i < 12; i++) cycle(1'b0, W'($urandom));
    check_eq("basic_u0_bits",  {20'd0, cap0[11:0]},  {20'd0, 12'b1011_0000_0000});
    check_eq("basic_u0_vld",   {20'd0, capv0[11:0]}, {20'd0, 12'b1111_0000_0000});
    check_eq("basic_u0_last",  {20'd0, capl0[11:0]}, {20'd0, 12'b0001_0000_0000});
    check_eq("basic_u0_ready", {20'd0, capr0[11:0]}, {20'd0, 12'b0001_1111_1111});
    check_eq("div_u1_bits",    {20'd0, cap1[11:0]},  {20'd0, 12'b111_111_000_111});
    check_eq("div_u1_last",    {20'd0, capl1[11:0]}, {20'd0, 12'b000_000_000_111});
    check_eq("div_u1_ready",   {20'd0, capr1[11:0]}, {20'd0, 12'b000_000_000_001});
    cycle(1'b0, 4'b0000);

    // Back-to-back on u0: 1011 then 0011 with valid held.
    cycle(1'b1, 4'b1011);
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'b0011);
    for (int i = 0; i < 4; i++) cycle(1'b0, 4'b0000);
    check_eq("b2b_u0_bits", {24'd0, cap0[7:0]},  {24'd0, 8'b1011_0011});
    check_eq("b2b_u0_vld",  {24'd0, capv0[7:0]}, {24'd0, 8'b1111_1111});
    check_eq("b2b_u0_last", {24'd0, capl0[7:0]}, {24'd0, 8'b0001_0001});
    for (int i = 0; i < 14; i++) cycle(1'b0, 4'b0000);

    // Reset after two bits of 1011, then 0011 goes out cleanly.
    cycle(1'b1, 4'b1011);
    cycle(1'b0, 4'b0000);
    cycle(1'b0, 4'b0000);
    mid_reset();
    cycle(1'b1, 4'b0011);
    for (int i = 0; i < 4; i++) cycle(1'b0, 4'b0000);
    check_eq("rst_u0_bits", {28'd0, cap0[3:0]}, {28'd0, 4'b0011});
    for (int i = 0; i < 10; i++) cycle(1'b0, 4'b0000);

    // Randomized handshake traffic, with one random-point reset.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) != 0), W'($urandom));
      if (i == 200) mid_reset();
    end
    for (int i = 0; i < 16; i++) cycle(1'b0, W'($urandom));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_paralelo_serie_tx.md
# reg_paralelo_serie_tx

Parallel-in, serial-out transmitter: accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit at a time, with a programmable number of clock cycles per bit. It is the sending end for the team's parallel registers. It feeds a serial line or a serial-in/parallel-out receiver, and marks each bit with a valid strobe and a last-bit flag.

## Interface
- WIDTH, 4, word width in bits (≥2)
- DIV, 1, clock cycles each bit is held on SO (≥1)
- MSB_FIRST, 1, 1: D[WIDTH-1] sent first; 0: D[0] sent first

- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- D  in  WIDTH  parallel word to send, sampled on handshake
- valid  in  1  D holds a word to send
- ready  out  1  block can accept a word this cycle
- SO  out  1  serial data out
- so_valid  out  1  SO carries a frame bit
- so_last  out  1  SO carries the final bit of the frame
- busy  out  1  a frame is in progress

## Operation
- States: IDLE, SHIFT.
- Registers:
  - shift register sr[WIDTH-1:0]
  - bit counter bit_cnt, 0..WIDTH-1
  - divider counter div_cnt, 0..DIV-1
- Reset (async, rst=1):
  - state=IDLE; sr, bit_cnt and div_cnt cleared.
  - SO=0, so_valid=0, so_last=0, busy=0.
  - ready=0 while rst is high.
- Handshake: a word is accepted on a rising edge where valid=1 and ready=1. D is don't-care at every other time.
- ready (combinational, gated by ~rst) = (state==IDLE) | (state==SHIFT & bit_cnt==WIDTH-1 & div_cnt==DIV-1).
- IDLE:
  - SO=0, so_valid=0, so_last=0, busy=0.
  - On accept: load sr=D, bit_cnt=0, div_cnt=0, go to SHIFT.
- SHIFT:
  - SO = sr[WIDTH-1] if MSB_FIRST, else sr[0].
  - so_valid=1, busy=1, so_last=(bit_cnt==WIDTH-1).
  - Each edge: div_cnt increments. At div_cnt==DIV-1, div_cnt wraps to 0, and:
    - if bit_cnt<WIDTH-1: bit_cnt increments and sr shifts toward the output end, filling with 0.
    - if bit_cnt==WIDTH-1 and accept occurs: reload sr=D, bit_cnt=0 and stay in SHIFT. This is back-to-back operation with no gap cycle.
    - if bit_cnt==WIDTH-1 and no accept: go to IDLE.
- SO, so_valid, so_last and busy are registered outputs (decoded from registered state and sr, no combinational path from inputs).
- Changes on D or valid while not ready have no effect.

## Timing
- Latency: accept at edge N puts bit 0 on SO from edge N until edge N+DIV.
- Bit k occupies cycles N+k·DIV .. N+(k+1)·DIV-1.
- A frame lasts WIDTH·DIV cycles. so_valid stays high for exactly that long per frame, and continuously across back-to-back frames.
- so_last is high for the final DIV cycles of each frame.
- ready is high during IDLE and during the final cycle of the last bit; it is low otherwise.
- Reset mid-frame:
  - outputs drop to 0 immediately, without waiting for clk.
  - the partial frame is discarded.
  - ready=1 in the first cycle after rst falls.
- valid held high continuously gives an uninterrupted bit stream with a new word accepted every WIDTH·DIV cycles.

## Test plan
- Basic MSB-first: WIDTH=4, DIV=1, MSB_FIRST=1; reset released, then D=4'b1011, valid=1 for one accept. Required: SO=1,0,1,1 on four consecutive cycles; so_valid=1 for those 4 cycles; so_last only on the 4th; ready=0 during cycles 1-3; IDLE afterwards with SO=0.
- Back-to-back: D=4'b1011 accepted, valid held, D changed to 4'b0011 before the last bit. Required: SO=1,0,1,1,0,0,1,1 with no gap; so_valid stays high for 8 cycles; so_last on cycles 4 and 8.
- Divider: DIV=3, D=4'b1011. Required: each bit held 3 cycles (SO=111 000 111 111); so_valid high 12 cycles; so_last on the final 3; ready high only on cycle 12.
- LSB-first: MSB_FIRST=0, D=4'b1011. Required: SO=1,1,0,1.
- Async reset mid-frame: assert rst between clock edges after 2 bits of 4'b1011. Required: SO, so_valid and busy go to 0 before the next edge; ready=0 while rst is high; after release, ready=1 and a new D=4'b0011 is sent as 0,0,1,1.
- Idle hold: valid=0 for 10 cycles after reset. Required: SO=0, so_valid=0, busy=0, ready=1 throughout, and D toggling has no effect.
